// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg: shared types and constants for the bus-sequenced MIPS control unit.
package mips_cpu_bus_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  // Encoding 3 is reserved; the sequencer treats it like MEM_NONE.
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_RSVD  = 2'd3
  } mem_op_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/mips_cpu_bus_watchdog.sv
// mips_cpu_bus_watchdog: counts consecutive stalled bus cycles and raises a
// sticky fired flag once the stall limit is reached. Only built when
// MIPS_CPU_BUS_WATCHDOG_EN is defined.
module mips_cpu_bus_watchdog #(
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic stall_i,
  output logic expire_o,
  output logic fired_o
);

  localparam logic [15:0] LIMIT = 16'(WDOG_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        fired_q, fired_d;

  // expire_o is high during the stalled cycle whose edge brings the count to WDOG_CYCLES
  always_comb begin
    expire_o = en_i && stall_i && (cnt_q == LIMIT);
    cnt_d    = cnt_q;
    fired_d  = fired_q | expire_o;
    if (en_i) begin
      cnt_d = stall_i ? cnt_q + 16'd1 : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  assign fired_o = fired_q;

endmodule

// File: rtl/mips_cpu_bus_seq.sv
// mips_cpu_bus_seq: multi-cycle FETCH/EXEC/MEM/WB sequencer driving a
// waitrequest-style memory bus, with a delay-slot pc/npc pair.
// Optional stall watchdog and bus_err port: define MIPS_CPU_BUS_WATCHDOG_EN.
module mips_cpu_bus_seq
  import mips_cpu_bus_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned WDOG_CYCLES  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  input  logic              waitrequest,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  input  logic [1:0]        mem_op,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_be,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [31:0]       mem_rdata,
  output logic              commit,
  output logic              active
`ifdef MIPS_CPU_BUS_WATCHDOG_EN
  ,
  output logic              bus_err
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rdata_q, rdata_d;
  logic        active_q, active_d;

  mem_op_e     op;
  logic        is_load, is_store;
  logic        req_rd, req_wr, commit_c;
  logic [31:0] addr_c, wdata_c;
  logic [3:0]  be_c;
  logic        wd_expire;

  assign op       = mem_op_e'(mem_op);
  assign is_load  = (op == MEM_LOAD);
  assign is_store = (op == MEM_STORE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    ir_d     = ir_q;
    rdata_d  = rdata_q;
    active_d = active_q;
    req_rd   = 1'b0;
    req_wr   = 1'b0;
    addr_c   = pc_q;
    be_c     = '0;
    wdata_c  = '0;
    commit_c = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (pc_q == '0) begin
          state_d  = HALT;
          active_d = 1'b0;
        end else begin
          req_rd = 1'b1;
          be_c   = 4'hF;
          if (!waitrequest) begin
            ir_d    = readdata;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          commit_c = 1'b1;
          state_d  = FETCH;
        end
      end
      MEM: begin
        addr_c  = mem_addr;
        be_c    = mem_be;
        req_rd  = is_load;
        req_wr  = is_store;
        wdata_c = mem_wdata;
        if (!waitrequest) begin
          if (is_load) rdata_d = readdata;
          state_d = WB;
        end
      end
      WB: begin
        commit_c = 1'b1;
        state_d  = FETCH;
      end
      HALT: begin
        active_d = 1'b0;
      end
      default: begin
        state_d = HALT;
      end
    endcase

    if (commit_c) begin
      pc_d  = npc_q;
      npc_d = branch_taken ? branch_target : npc_q + INSTR_BYTES;
    end

    if (wd_expire) begin
      state_d  = HALT;
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_VECTOR;
      npc_q    <= RESET_VECTOR + INSTR_BYTES;
      ir_q     <= '0;
      rdata_q  <= '0;
      active_q <= 1'b1;
    end else if (clk_enable) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      ir_q     <= ir_d;
      rdata_q  <= rdata_d;
      active_q <= active_d;
    end
  end

`ifdef MIPS_CPU_BUS_WATCHDOG_EN
  logic stall;
  logic wd_fired;

  assign stall = (req_rd | req_wr) & waitrequest;

  mips_cpu_bus_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (reset),
    .en_i     (clk_enable),
    .stall_i  (stall),
    .expire_o (wd_expire),
    .fired_o  (wd_fired)
  );

  assign bus_err = wd_fired;
`else
  logic [15:0] wdog_unused;

  assign wd_expire   = 1'b0;
  assign wdog_unused = 16'(WDOG_CYCLES);
`endif

  // Requests are gated by reset so an in-flight transfer drops asynchronously.
  assign address    = addr_c[ADDR_W-1:0];
  assign read       = req_rd & reset;
  assign write      = req_wr & reset;
  assign byteenable = reset ? be_c : '0;
  assign writedata  = wdata_c;
  assign commit     = commit_c & clk_enable & reset;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign mem_rdata  = rdata_q;
  assign active     = active_q;

endmodule

// File: tb/tb_mips_cpu_bus_seq.sv
// tb_mips_cpu_bus_seq: scoreboard bench for mips_cpu_bus_seq.
// Watchdog scenario is exercised when MIPS_CPU_BUS_WATCHDOG_EN is defined.
module tb_mips_cpu_bus_seq;
  import mips_cpu_bus_pkg::*;

  localparam logic [31:0] RV = 32'hBFC00000;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [31:0] address;
  logic        read, write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] pc, ir;
  logic [1:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mem_rdata;
  logic        commit, active;
`ifdef MIPS_CPU_BUS_WATCHDOG_EN
  logic        bus_err;
`endif

  int checks   = 0;
  int failures = 0;

  bus_t        bus_q[$];
  logic [31:0] commit_q[$];

  mips_cpu_bus_seq #(
    .RESET_VECTOR (RV),
    .ADDR_W       (32),
    .WDOG_CYCLES  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .waitrequest   (waitrequest),
    .pc            (pc),
    .ir            (ir),
    .mem_op        (mem_op),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_rdata     (mem_rdata),
    .commit        (commit),
    .active        (active)
`ifdef MIPS_CPU_BUS_WATCHDOG_EN
    ,
    .bus_err       (bus_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1);
  end

  // Scoreboard: accepted bus transfers and commits are matched against queued expectations.
  always @(negedge clk) begin
    bus_t got_b, exp_b;
    logic [31:0] exp_pc;
    if (reset === 1'b1 && clk_enable === 1'b1 && (read === 1'b1 || write === 1'b1) && waitrequest === 1'b0) begin
      checks++;
      got_b = '{addr: address, rd: read, wr: write, be: byteenable, wdata: (write ? writedata : 32'h0)};
      if (bus_q.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected got=%h required=none", got_b);
      end else begin
        exp_b = bus_q.pop_front();
        if (got_b !== exp_b) begin
          failures++;
          $display("FAIL bus_xfer got=%h required=%h", got_b, exp_b);
        end
      end
    end
    if (commit === 1'b1) begin
      checks++;
      if (commit_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected pc=%h required=none", pc);
      end else begin
        exp_pc = commit_q.pop_front();
        if (pc !== exp_pc) begin
          failures++;
          $display("FAIL commit_pc got=%h required=%h", pc, exp_pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_enable = 1'b1; waitrequest = 1'b0; readdata = '0;
    mem_op = 2'd0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    branch_taken = 1'b0; branch_target = '0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({read, write, commit} !== 3'b000) begin
      failures++; $display("FAIL reset_req got=%b required=000", {read, write, commit});
    end
    checks++;
    if (byteenable !== 4'h0) begin
      failures++; $display("FAIL reset_be got=%h required=0", byteenable);
    end
    checks++;
    if (pc !== RV) begin
      failures++; $display("FAIL reset_pc got=%h required=%h", pc, RV);
    end
    checks++;
    if (ir !== 32'h0 || mem_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_ir_rdata got=%h/%h required=0/0", ir, mem_rdata);
    end
    checks++;
    if (active !== 1'b1) begin
      failures++; $display("FAIL reset_active got=%b required=1", active);
    end
`ifdef MIPS_CPU_BUS_WATCHDOG_EN
    checks++;
    if (bus_err !== 1'b0) begin
      failures++; $display("FAIL reset_bus_err got=%b required=0", bus_err);
    end
`endif
    step();
    reset = 1'b1;
  endtask

  task automatic test_fetch_exec();
    readdata = 32'h24020005; mem_op = 2'd0; waitrequest = 1'b0;
    bus_q.push_back('{addr: RV, rd: 1'b1, wr: 1'b0, be: 4'hF, wdata: 32'h0});
    commit_q.push_back(RV);
    @(negedge clk);
    checks++;
    if (read !== 1'b1 || address !== RV) begin
      failures++; $display("FAIL first_fetch got=%b/%h required=1/%h", read, address, RV);
    end
    step();
    @(negedge clk);
    checks++;
    if (commit !== 1'b1 || read !== 1'b0 || ir !== 32'h24020005) begin
      failures++; $display("FAIL first_exec got=%b/%b/%h required=1/0/24020005", commit, read, ir);
    end
    step();
  endtask

  task automatic test_wait_stall();
    waitrequest = 1'b1; readdata = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        waitrequest = 1'b0; readdata = 32'h00851020;
        bus_q.push_back('{addr: RV + 32'd4, rd: 1'b1, wr: 1'b0, be: 4'hF, wdata: 32'h0});
        commit_q.push_back(RV + 32'd4);
      end
      @(negedge clk);
      checks++;
      if (read !== 1'b1 || address !== RV + 32'd4 || byteenable !== 4'hF) begin
        failures++; $display("FAIL stall_hold_%0d got=%b/%h/%h required=1/%h/f", i, read, address, byteenable, RV + 32'd4);
      end
      checks++;
      if (ir !== 32'h24020005) begin
        failures++; $display("FAIL stall_ir_%0d got=%h required=24020005", i, ir);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (ir !== 32'h00851020 || commit !== 1'b1) begin
      failures++; $display("FAIL stall_latch got=%h/%b required=00851020/1", ir, commit);
    end
    step();
  endtask

  task automatic test_store();
    readdata = 32'hAC820000; mem_op = 2'd2; mem_addr = 32'h1000;
    mem_wdata = 32'hDEADBEEF; mem_be = 4'b0011;
    bus_q.push_back('{addr: RV + 32'd8, rd: 1'b1, wr: 1'b0, be: 4'hF, wdata: 32'h0});
    bus_q.push_back('{addr: 32'h1000, rd: 1'b0, wr: 1'b1, be: 4'b0011, wdata: 32'hDEADBEEF});
    commit_q.push_back(RV + 32'd8);
    @(negedge clk);
    checks++;
    if (read !== 1'b1 || address !== RV + 32'd8) begin
      failures++; $display("FAIL store_fetch got=%b/%h required=1/%h", read, address, RV + 32'd8);
    end
    step();
    @(negedge clk);
    checks++;
    if ({read, write, commit} !== 3'b000) begin
      failures++; $display("FAIL store_exec got=%b required=000", {read, write, commit});
    end
    step();
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || read !== 1'b0 || address !== 32'h1000 || byteenable !== 4'b0011 || writedata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL store_mem got=%b/%b/%h/%h/%h required=1/0/00001000/3/deadbeef", write, read, address, byteenable, writedata);
    end
    step();
    @(negedge clk);
    checks++;
    if (commit !== 1'b1 || write !== 1'b0) begin
      failures++; $display("FAIL store_wb got=%b/%b required=1/0", commit, write);
    end
    step();
    mem_op = 2'd0;
  endtask

  task automatic test_load_freeze();
    readdata = 32'h8C830000; mem_op = 2'd1; mem_addr = 32'h2000;
    mem_be = 4'hF; mem_wdata = 32'h55555555;
    bus_q.push_back('{addr: RV + 32'd12, rd: 1'b1, wr: 1'b0, be: 4'hF, wdata: 32'h0});
    commit_q.push_back(RV + 32'd12);
    @(negedge clk);
    checks++;
    if (pc !== RV + 32'd12 || read !== 1'b1) begin
      failures++; $display("FAIL store_latency_pc got=%h/%b required=%h/1", pc, read, RV + 32'd12);
    end
    step();
    @(negedge clk);
    checks++;
    if (commit !== 1'b0) begin
      failures++; $display("FAIL load_exec_commit got=%b required=0", commit);
    end
    step();
    waitrequest = 1'b1; readdata = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if (read !== 1'b1 || write !== 1'b0 || address !== 32'h2000) begin
      failures++; $display("FAIL load_mem got=%b/%b/%h required=1/0/00002000", read, write, address);
    end
    step();
    clk_enable = 1'b0; waitrequest = 1'b0; readdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (read !== 1'b1 || address !== 32'h2000 || byteenable !== 4'hF || commit !== 1'b0) begin
        failures++; $display("FAIL freeze_out_%0d got=%b/%h/%h/%b required=1/00002000/f/0", i, read, address, byteenable, commit);
      end
      checks++;
      if (mem_rdata !== 32'h0 || pc !== RV + 32'd12) begin
        failures++; $display("FAIL freeze_state_%0d got=%h/%h required=0/%h", i, mem_rdata, pc, RV + 32'd12);
      end
      step();
    end
    clk_enable = 1'b1;
    bus_q.push_back('{addr: 32'h2000, rd: 1'b1, wr: 1'b0, be: 4'hF, wdata: 32'h0});
    step();
    @(negedge clk);
    checks++;
    if (commit !== 1'b1 || mem_rdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL load_wb got=%b/%h required=1/cafef00d", commit, mem_rdata);
    end
    step();
    mem_op = 2'd0;
  endtask

  task automatic test_branch_halt();
    readdata = 32'h10000000; mem_op = 2'd0; branch_taken = 1'b1; branch_target = 32'h0;
    bus_q.push_back('{addr: RV + 32'd16, rd: 1'b1, wr: 1'b0, be: 4'hF, wdata: 32'h0});
    commit_q.push_back(RV + 32'd16);
    @(negedge clk);
    checks++;
    if (address !== RV + 32'd16 || read !== 1'b1) begin
      failures++; $display("FAIL branch_fetch got=%h/%b required=%h/1", address, read, RV + 32'd16);
    end
    step();
    @(negedge clk);
    checks++;
    if (commit !== 1'b1) begin
      failures++; $display("FAIL branch_commit got=%b required=1", commit);
    end
    step();
    branch_taken = 1'b0; readdata = 32'h00000000;
    bus_q.push_back('{addr: RV + 32'd20, rd: 1'b1, wr: 1'b0, be: 4'hF, wdata: 32'h0});
    commit_q.push_back(RV + 32'd20);
    @(negedge clk);
    checks++;
    if (address !== RV + 32'd20 || read !== 1'b1) begin
      failures++; $display("FAIL delay_slot got=%h/%b required=%h/1", address, read, RV + 32'd20);
    end
    step();
    step();
    @(negedge clk);
    checks++;
    if (read !== 1'b0 || write !== 1'b0 || pc !== 32'h0 || active !== 1'b1) begin
      failures++; $display("FAIL pc0_fetch got=%b/%b/%h/%b required=0/0/0/1", read, write, pc, active);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({active, read, write, commit} !== 4'b0000) begin
        failures++; $display("FAIL halt_%0d got=%b required=0000", i, {active, read, write, commit});
      end
      step();
    end
    checks++;
    if (bus_q.size() != 0 || commit_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d/%0d required=0/0", bus_q.size(), commit_q.size());
    end
  endtask

  task automatic test_async_reset();
    reset = 1'b0; waitrequest = 1'b1; mem_op = 2'd0;
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (read !== 1'b1 || address !== RV) begin
      failures++; $display("FAIL restart_fetch got=%b/%h required=1/%h", read, address, RV);
    end
    step();
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({read, write} !== 2'b00 || byteenable !== 4'h0) begin
      failures++; $display("FAIL async_drop got=%b/%h required=00/0", {read, write}, byteenable);
    end
    checks++;
    if (pc !== RV || active !== 1'b1) begin
      failures++; $display("FAIL async_state got=%h/%b required=%h/1", pc, active, RV);
    end
  endtask

`ifdef MIPS_CPU_BUS_WATCHDOG_EN
  task automatic test_watchdog();
    step();
    reset = 1'b1; waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (read !== 1'b1 || bus_err !== 1'b0 || active !== 1'b1) begin
        failures++; $display("FAIL wdog_pre_%0d got=%b/%b/%b required=1/0/1", i, read, bus_err, active);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_err !== 1'b1 || active !== 1'b0 || read !== 1'b0) begin
        failures++; $display("FAIL wdog_fired_%0d got=%b/%b/%b required=1/0/0", i, bus_err, active, read);
      end
      step();
    end
  endtask
`else
  task automatic test_stall_forever();
    step();
    reset = 1'b1; waitrequest = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (read !== 1'b1 || active !== 1'b1 || address !== RV) begin
        failures++; $display("FAIL stall_forever_%0d got=%b/%b/%h required=1/1/%h", i, read, active, address, RV);
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_exec();
    test_wait_stall();
    test_store();
    test_load_freeze();
    test_branch_halt();
    test_async_reset();
`ifdef MIPS_CPU_BUS_WATCHDOG_EN
    test_watchdog();
`else
    test_stall_forever();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
